// File: rtl/sram_port_arbiter.sv
// Two-requester SRAM port arbiter: VGA-priority with renderer anti-starvation,
// a one-entry command slot and an owner FIFO that routes in-order read returns.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W          = 20,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned STARVE_LIMIT    = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              rnd_req,
  input  logic              rnd_we,
  input  logic [ADDR_W-1:0] rnd_addr,
  input  logic [DATA_W-1:0] rnd_wdata,
  output logic              rnd_ack,
  output logic [DATA_W-1:0] rnd_rdata,
  output logic              rnd_rvalid,
  output logic              mem_cmd_valid,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_cmd_wdata,
  input  logic              mem_cmd_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              err_unexpected
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_d;
  logic                cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STV_W-1:0]    starve_q, starve_d;
  logic                err_q, err_d;
  logic                owner_q [MAX_OUTSTANDING];

  logic slot_free, rd_ok, vga_elig, rnd_elig, starve_hit;
  logic grant_vga, grant_rnd, push, pop, head_owner;

  assign slot_free  = (state_q == IDLE) || mem_cmd_ready;
  assign rd_ok      = cnt_q < CNT_W'(MAX_OUTSTANDING);
  assign vga_elig   = vga_req && rd_ok;
  assign rnd_elig   = rnd_req && (rnd_we || rd_ok);
  assign starve_hit = starve_q >= STV_W'(STARVE_LIMIT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: a free slot is refilled by a winner or drains to IDLE
  always_comb begin
    state_d = state_q;
    if (slot_free) state_d = (grant_vga || grant_rnd) ? BUSY : IDLE;
  end

  // Grant outputs: VGA first unless the renderer has waited long enough
  always_comb begin
    grant_vga = 1'b0;
    grant_rnd = 1'b0;
    if (!rst && slot_free) begin
      if (rnd_elig && (starve_hit || !vga_elig)) grant_rnd = 1'b1;
      else if (vga_elig)                         grant_vga = 1'b1;
    end
  end

  assign push       = grant_vga || (grant_rnd && !rnd_we);
  assign pop        = mem_rvalid && (cnt_q != '0);
  assign head_owner = owner_q[rd_ptr_q];

  always_comb begin
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    err_d       = err_q;
    if (grant_vga) begin
      cmd_we_d    = 1'b0;
      cmd_addr_d  = vga_addr;
      cmd_wdata_d = '0;
    end else if (grant_rnd) begin
      cmd_we_d    = rnd_we;
      cmd_addr_d  = rnd_addr;
      cmd_wdata_d = rnd_wdata;
    end
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    if (grant_rnd)                   starve_d = '0;
    else if (rnd_req && !starve_hit) starve_d = starve_q + STV_W'(1);
    if (mem_rvalid && (cnt_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      err_q       <= err_d;
    end
  end

  // Owner storage needs no reset: occupancy alone says which entries are live
  always_ff @(posedge clk) begin
    if (push) owner_q[wr_ptr_q] <= grant_rnd;
  end

  assign vga_ack        = grant_vga;
  assign rnd_ack        = grant_rnd;
  assign vga_rvalid     = pop && !head_owner;
  assign rnd_rvalid     = pop && head_owner;
  assign vga_rdata      = vga_rvalid ? mem_rdata : '0;
  assign rnd_rdata      = rnd_rvalid ? mem_rdata : '0;
  assign mem_cmd_valid  = (state_q == BUSY);
  assign mem_cmd_we     = cmd_we_q;
  assign mem_cmd_addr   = cmd_addr_q;
  assign mem_cmd_wdata  = cmd_wdata_q;
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based behavioural model.
module tb_sram_port_arbiter;

  localparam int unsigned AW   = 20;
  localparam int unsigned DW   = 32;
  localparam int unsigned SLIM = 8;
  localparam int unsigned MAXO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          vga_req, vga_ack, vga_rvalid;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rdata;
  logic          rnd_req, rnd_we, rnd_ack, rnd_rvalid;
  logic [AW-1:0] rnd_addr;
  logic [DW-1:0] rnd_wdata, rnd_rdata;
  logic          mem_cmd_valid, mem_cmd_we, mem_cmd_ready, mem_rvalid;
  logic [AW-1:0] mem_cmd_addr;
  logic [DW-1:0] mem_cmd_wdata, mem_rdata;
  logic          err_unexpected;

  sram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SLIM), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .rnd_req(rnd_req), .rnd_we(rnd_we), .rnd_addr(rnd_addr),
    .rnd_wdata(rnd_wdata), .rnd_ack(rnd_ack), .rnd_rdata(rnd_rdata),
    .rnd_rvalid(rnd_rvalid),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_cmd_ready(mem_cmd_ready), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_busy, m_we, m_err, m_ev, m_er;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit          m_q[$];
  int          m_starve;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_we = 0; m_err = 0; m_ev = 0; m_er = 0;
    m_addr = '0; m_wdata = '0; m_starve = 0;
    m_q.delete();
  endtask

  task automatic idle_inputs();
    vga_req = 0; vga_addr = '0; rnd_req = 0; rnd_we = 0; rnd_addr = '0;
    rnd_wdata = '0; mem_cmd_ready = 0; mem_rdata = '0; mem_rvalid = 0;
  endtask

  // Check all outputs at the negedge against the model, then commit the model's cycle
  task automatic sample(input string tag);
    int n;
    bit fr, ve, re, ev, er, pop, own;
    @(negedge clk);
    n  = m_q.size();
    fr = !m_busy || mem_cmd_ready;
    ve = vga_req && (n < int'(MAXO));
    re = rnd_req && (rnd_we || (n < int'(MAXO)));
    ev = 0; er = 0;
    if (fr) begin
      if (re && (m_starve >= int'(SLIM) || !ve)) er = 1;
      else if (ve) ev = 1;
    end
    pop = mem_rvalid && (n > 0);
    own = pop ? m_q[0] : 1'b0;
    chk({tag, ".vga_ack"}, 64'(vga_ack), 64'(ev));
    chk({tag, ".rnd_ack"}, 64'(rnd_ack), 64'(er));
    chk({tag, ".cmd_valid"}, 64'(mem_cmd_valid), 64'(m_busy));
    if (m_busy) begin
      chk({tag, ".cmd_addr"}, 64'(mem_cmd_addr), 64'(m_addr));
      chk({tag, ".cmd_we"}, 64'(mem_cmd_we), 64'(m_we));
      if (m_we) chk({tag, ".cmd_wdata"}, 64'(mem_cmd_wdata), 64'(m_wdata));
    end
    chk({tag, ".vga_rvalid"}, 64'(vga_rvalid), 64'(pop && !own));
    chk({tag, ".rnd_rvalid"}, 64'(rnd_rvalid), 64'(pop && own));
    chk({tag, ".vga_rdata"}, 64'(vga_rdata), (pop && !own) ? 64'(mem_rdata) : 64'd0);
    chk({tag, ".rnd_rdata"}, 64'(rnd_rdata), (pop && own) ? 64'(mem_rdata) : 64'd0);
    chk({tag, ".err"}, 64'(err_unexpected), 64'(m_err));
    if (pop) void'(m_q.pop_front());
    if (mem_rvalid && n == 0) m_err = 1;
    if (ev) begin
      m_busy = 1; m_we = 0; m_addr = vga_addr; m_q.push_back(1'b0);
    end else if (er) begin
      m_busy = 1; m_we = rnd_we; m_addr = rnd_addr; m_wdata = rnd_wdata;
      if (!rnd_we) m_q.push_back(1'b1);
    end else if (fr) begin
      m_busy = 0;
    end
    if (er) m_starve = 0;
    else if (rnd_req && m_starve < int'(SLIM)) m_starve++;
    m_ev = ev; m_er = er;
  endtask

  task automatic advance();
    @(posedge clk); #1;
  endtask

  task automatic step(input string tag);
    sample(tag);
    advance();
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    @(posedge clk); #1;
    chk("rst.cmd_valid", 64'(mem_cmd_valid), 64'd0);
    chk("rst.cmd_addr", 64'(mem_cmd_addr), 64'd0);
    chk("rst.err", 64'(err_unexpected), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  initial begin
    int nv, nr, first_r;
    rst = 1;
    idle_inputs();
    model_clear();
    do_reset();
    step("post_reset");

    // Starvation ratio: VGA reads vs renderer writes, both held continuously
    do_reset();
    vga_req = 1; rnd_req = 1; rnd_we = 1; rnd_addr = AW'(20'h00AB0);
    rnd_wdata = 32'h0BAD_F00D; mem_cmd_ready = 1;
    nv = 0; nr = 0; first_r = 0;
    for (int i = 1; i <= 18; i++) begin
      vga_addr   = AW'(i);
      mem_rvalid = (m_q.size() > 0);
      mem_rdata  = DW'(i * 3);
      sample("ratio");
      if (vga_ack) nv++;
      if (rnd_ack) begin
        nr++;
        if (first_r == 0) first_r = i;
      end
      advance();
    end
    chk("ratio.vga_count", 64'(nv), 64'd16);
    chk("ratio.rnd_count", 64'(nr), 64'd2);
    chk("ratio.first_rnd", 64'(first_r), 64'd9);

    // Outstanding limit
    do_reset();
    mem_cmd_ready = 1; vga_req = 1;
    for (int i = 0; i < 4; i++) begin
      vga_addr = AW'(32'h100 + i);
      step("fill");
    end
    vga_addr = AW'(20'h00200);
    sample("full");
    chk("full.no_ack", 64'(vga_ack), 64'd0);
    advance();
    rnd_req = 1; rnd_we = 1; rnd_addr = AW'(20'h00300); rnd_wdata = 32'h1234_5678;
    sample("full_wr");
    chk("full_wr.rnd_ack", 64'(rnd_ack), 64'd1);
    advance();
    rnd_req = 0;
    mem_rvalid = 1; mem_rdata = 32'hC0FF_EE00;
    sample("full_ret");
    chk("full_ret.no_ack", 64'(vga_ack), 64'd0);
    chk("full_ret.rvalid", 64'(vga_rvalid), 64'd1);
    advance();
    mem_rvalid = 0;
    sample("full_next");
    chk("full_next.ack", 64'(vga_ack), 64'd1);
    advance();
    vga_req = 0;
    step("full_idle");

    // Interleaved read returns routed by owner
    do_reset();
    mem_cmd_ready = 1;
    vga_req = 1; vga_addr = AW'(20'h00010);
    step("il_vga");
    vga_req = 0; rnd_req = 1; rnd_we = 0; rnd_addr = AW'(20'h00020);
    step("il_rnd");
    rnd_req = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA_0000;
    sample("il_ret0");
    chk("il_ret0.vga_data", 64'(vga_rdata), 64'hAAAA_0000);
    chk("il_ret0.rnd_rvalid", 64'(rnd_rvalid), 64'd0);
    advance();
    mem_rdata = 32'h5555_FFFF;
    sample("il_ret1");
    chk("il_ret1.rnd_data", 64'(rnd_rdata), 64'h5555_FFFF);
    chk("il_ret1.vga_rvalid", 64'(vga_rvalid), 64'd0);
    advance();
    mem_rvalid = 0;
    step("il_idle");

    // Back-pressure: slot holds while not ready
    do_reset();
    mem_cmd_ready = 0;
    rnd_req = 1; rnd_we = 1; rnd_addr = AW'(20'h00123); rnd_wdata = 32'hDEAD_BEEF;
    step("bp_load");
    rnd_req = 0; vga_req = 1; vga_addr = AW'(20'h00456);
    for (int i = 0; i < 3; i++) begin
      sample("bp_hold");
      chk("bp_hold.no_ack", 64'(vga_ack), 64'd0);
      chk("bp_hold.addr", 64'(mem_cmd_addr), 64'h123);
      advance();
    end
    mem_cmd_ready = 1;
    sample("bp_release");
    chk("bp_release.ack", 64'(vga_ack), 64'd1);
    advance();
    vga_req = 0; mem_cmd_ready = 0;
    sample("bp_after");
    chk("bp_after.addr", 64'(mem_cmd_addr), 64'h456);
    advance();

    // Unexpected return is sticky until reset
    do_reset();
    mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    sample("unexp");
    chk("unexp.no_rvalid", 64'(vga_rvalid | rnd_rvalid), 64'd0);
    advance();
    mem_rvalid = 0;
    step("unexp_hold1");
    step("unexp_hold2");
    chk("unexp.sticky", 64'(err_unexpected), 64'd1);
    do_reset();
    chk("unexp.cleared", 64'(err_unexpected), 64'd0);

    // Asynchronous reset while busy with two reads outstanding
    do_reset();
    mem_cmd_ready = 1; vga_req = 1; vga_addr = AW'(20'h00501);
    step("ar_rd0");
    vga_addr = AW'(20'h00502);
    step("ar_rd1");
    mem_cmd_ready = 0; vga_addr = AW'(20'h00503);
    sample("ar_busy");
    chk("ar_busy.valid", 64'(mem_cmd_valid), 64'd1);
    advance();
    #2 rst = 1;
    #1;
    chk("ar.valid0", 64'(mem_cmd_valid), 64'd0);
    chk("ar.addr0", 64'(mem_cmd_addr), 64'd0);
    chk("ar.acks0", 64'(vga_ack | rnd_ack), 64'd0);
    chk("ar.err0", 64'(err_unexpected), 64'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    step("ar_idle0");
    step("ar_idle1");
    chk("ar.idle_valid", 64'(mem_cmd_valid), 64'd0);
    mem_rvalid = 1; mem_rdata = 32'h0000_0501;
    step("ar_stale");
    mem_rvalid = 0;
    sample("ar_stale_err");
    chk("ar.stale_err", 64'(err_unexpected), 64'd1);
    advance();
    vga_req = 1; vga_addr = AW'(20'h00600);
    step("ar_new");
    vga_req = 0;
    step("ar_done");

    // Randomized traffic; requesters hold their request until acked
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (!vga_req && $urandom_range(0, 2) == 0) begin
        vga_req = 1; vga_addr = AW'($urandom);
      end
      if (!rnd_req && $urandom_range(0, 2) == 0) begin
        rnd_req = 1; rnd_we = 1'($urandom); rnd_addr = AW'($urandom);
        rnd_wdata = DW'($urandom);
      end
      mem_cmd_ready = ($urandom_range(0, 3) != 0);
      mem_rvalid    = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_rdata     = DW'($urandom);
      sample("rand");
      advance();
      if (m_ev) vga_req = 0;
      if (m_er) rnd_req = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, SRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, renderer-wait cycles that force one renderer grant.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, in-flight reads allowed, a power of 2 and at least 2.
REQ-005 SHALL have ports, one per line:
 clk  in  1  single clock; all logic on its rising edge
 rst  in  1  reset, asynchronous, active-high
 vga_req  in  1  VGA read request, held until vga_ack
 vga_addr  in  ADDR_W  VGA read address
 vga_ack  out  1  one-cycle grant pulse
 vga_rdata  out  DATA_W  VGA read data
 vga_rvalid  out  1  vga_rdata valid, one cycle
 rnd_req  in  1  renderer request, held until rnd_ack
 rnd_we  in  1  1 = write, 0 = read
 rnd_addr  in  ADDR_W  renderer address
 rnd_wdata  in  DATA_W  renderer write data
 rnd_ack  out  1  one-cycle grant pulse
 rnd_rdata  out  DATA_W  renderer read data
 rnd_rvalid  out  1  rnd_rdata valid, one cycle
 mem_cmd_valid  out  1  command slot holds a command
 mem_cmd_we  out  1  command is a write
 mem_cmd_addr  out  ADDR_W  command address
 mem_cmd_wdata  out  DATA_W  command write data
 mem_cmd_ready  in  1  SRAM controller accepts the command this cycle
 mem_rdata  in  DATA_W  read return data
 mem_rvalid  in  1  read return, in issue order
 err_unexpected  out  1  sticky flag: mem_rvalid arrived with no read outstanding

Function
REQ-006 SHALL keep a one-entry registered command slot driving all mem_cmd_* outputs, with states IDLE (slot empty) and BUSY (mem_cmd_valid=1).
REQ-007 SHALL treat the slot as free when in IDLE, or when in BUSY with mem_cmd_ready=1 that cycle; this allows back-to-back issue.
REQ-008 SHALL, in a cycle where the slot is free, load the winner's command and pulse that requester's ack for exactly that cycle; next state BUSY.
REQ-009 SHALL, in a cycle where the slot is free and there is no eligible request, go to IDLE.
REQ-010 SHALL treat a VGA request as eligible only when reads outstanding < MAX_OUTSTANDING.
REQ-011 SHALL treat a renderer read as eligible only when reads outstanding < MAX_OUTSTANDING; a renderer write is always eligible.
REQ-012 SHALL give VGA priority, except when starve_cnt >= STARVE_LIMIT and the renderer is eligible; the renderer then wins.
REQ-013 SHALL increment starve_cnt (saturating at STARVE_LIMIT) each cycle rnd_req=1 without rnd_ack, and clear it on rnd_ack.
REQ-014 SHALL never assert vga_ack and rnd_ack in the same cycle.
REQ-015 SHALL, when loading a read, push an owner bit (0=VGA, 1=renderer) into an owner FIFO of depth MAX_OUTSTANDING; the outstanding count is the FIFO occupancy.
REQ-016 SHALL not push an owner bit for writes; writes produce no read return.
REQ-017 SHALL, on mem_rvalid with the FIFO non-empty, pop the head and drive the owner's rdata and rvalid in the same cycle (combinational route, zero latency).
REQ-018 SHALL drive the non-owner rvalid to 0.
REQ-019 SHALL, on a simultaneous push and pop, leave occupancy unchanged; the popped entry is the old head.
REQ-020 SHALL, on mem_rvalid with the FIFO empty, drop the data, assert no rvalid, and set err_unexpected until reset.
REQ-021 SHALL wrap the FIFO pointers modulo MAX_OUTSTANDING.
REQ-022 SHALL hold the slot contents stable while BUSY and mem_cmd_ready=0.

Reset
REQ-023 SHALL, while rst=1 (asynchronously), force IDLE, empty FIFO, starve_cnt=0, err_unexpected=0, and all outputs 0.
REQ-024 SHALL discard any command or outstanding reads on reset mid-operation; returns arriving after reset hit REQ-020.

Verification
REQ-025 Bench SHALL cover: both requesters held continuously with writes, mem_cmd_ready=1 -> VGA acked 8 cycles, then 1 rnd_ack, repeating 8:1.
REQ-026 Bench SHALL cover: 4 VGA reads issued, no mem_rvalid -> 5th vga_req gets no ack; renderer write still acked; one mem_rvalid -> 5th read acked next free cycle.
REQ-027 Bench SHALL cover: interleaved reads VGA A=0x00010, renderer A=0x00020, returns 0xAAAA0000 then 0x5555FFFF -> vga_rvalid with 0xAAAA0000, then rnd_rvalid with 0x5555FFFF.
REQ-028 Bench SHALL cover: mem_cmd_ready=0 for 3 cycles while BUSY -> mem_cmd_* stable and no acks; ready=1 -> next command loaded in the same cycle.
REQ-029 Bench SHALL cover: mem_rvalid with an empty FIFO -> err_unexpected=1 and stays set; rst pulse -> err_unexpected=0.
REQ-030 Bench SHALL cover: rst asserted while BUSY with 2 reads outstanding -> outputs 0 immediately (async); after release, idle until a new req.
